// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared types and helpers for the two-master bus arbiter.
// Holds the arbiter FSM state encoding, the owner encoding and the
// default bus geometry used by the interface and the top level.
package bus_arbiter_2to1_pkg;

  localparam int ARB_ADDR_W_DEFAULT = 32;
  localparam int ARB_BUS_W_DEFAULT  = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef enum logic {
    OWNER_M0,
    OWNER_M1
  } arb_owner_e;

  // The master that did not hold the bus last; used for alternation.
  function automatic arb_owner_e other_owner(input arb_owner_e o);
    return (o == OWNER_M0) ? OWNER_M1 : OWNER_M0;
  endfunction

endpackage

// File: rtl/bus_arbiter_2to1_if.sv
// re/we/ready/r_data_valid bus port.
// The master modport is the requesting side (drives address, data and
// strobes); the slave modport is the responding side (drives read data
// and the ready / r_data_valid handshakes).
interface bus_arbiter_2to1_if
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int AddrBusWidth = ARB_ADDR_W_DEFAULT,
  parameter int BusWidth     = ARB_BUS_W_DEFAULT
) ();

  logic [AddrBusWidth-1:0] addr;
  logic [BusWidth-1:0]     w_data;
  logic [BusWidth/8-1:0]   w_sel;
  logic                    re;
  logic                    we;
  logic [BusWidth-1:0]     r_data;
  logic                    ready;
  logic                    r_data_valid;

  modport master (
    output addr,
    output w_data,
    output w_sel,
    output re,
    output we,
    input  r_data,
    input  ready,
    input  r_data_valid
  );

  modport slave (
    input  addr,
    input  w_data,
    input  w_sel,
    input  re,
    input  we,
    output r_data,
    output ready,
    output r_data_valid
  );

endinterface

// File: rtl/bus_arbiter_2to1_pick.sv
// Combinational winner selection between the two bus masters.
// Build option BUS_ARB_ROUND_ROBIN_EN:
//   defined   - a contested pick goes to the master that did not win last
//   undefined - fixed priority, m1 (load/store) wins every contest
// An uncontested pick always goes to the only requester. When nobody
// requests, the output is OWNER_M0 and is ignored by the caller.
module bus_arbiter_2to1_pick
  import bus_arbiter_2to1_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_owner_e last,
  output arb_owner_e winner
);

`ifndef BUS_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the grant history.
  logic unused_last;
  assign unused_last = last;
`endif

  // Resolve a contest according to the build-time policy.
  always_comb begin
    winner = OWNER_M0;
    if (req0 && req1) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      winner = other_owner(last);
`else
      winner = OWNER_M1;
`endif
    end else if (req1) begin
      winner = OWNER_M1;
    end
  end

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Two-master bus arbiter: m0 = instruction fetch, m1 = load/store, one
// shared port s towards the width adapter.
// A request is granted combinationally in the cycle it appears (zero
// grant latency) and the owner is locked until its read returns
// r_data_valid or its write returns ready. A same-cycle completion keeps
// the arbiter idle so the next grant can happen one cycle later.
// Build option BUS_ARB_ROUND_ROBIN_EN selects alternating grants on
// contest; without it m1 has fixed priority (see bus_arbiter_2to1_pick).
module bus_arbiter_2to1
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int AddrBusWidth = ARB_ADDR_W_DEFAULT,
  parameter int BusWidth     = ARB_BUS_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  bus_arbiter_2to1_if.slave  m0,
  bus_arbiter_2to1_if.slave  m1,
  bus_arbiter_2to1_if.master s
);

  localparam int SelW = BusWidth / 8;

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  arb_owner_e last_q,  last_d;

  arb_owner_e winner;
  arb_owner_e sel_owner;
  logic       req0;
  logic       req1;
  logic       granted;
  logic       done;

  logic [AddrBusWidth-1:0] sel_addr;
  logic [BusWidth-1:0]     sel_w_data;
  logic [SelW-1:0]         sel_w_sel;
  logic                    sel_re;
  logic                    sel_we;

  assign req0 = m0.re | m0.we;
  assign req1 = m1.re | m1.we;

  bus_arbiter_2to1_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (winner)
  );

  // Decide who drives the shared port this cycle: the fresh winner when
  // idle, the locked owner when busy. An owner that has dropped its
  // request (abort) gets no grant, and nothing is granted during reset.
  always_comb begin
    sel_owner = owner_q;
    granted   = 1'b0;
    if (state_q == ARB_IDLE) begin
      sel_owner = winner;
      granted   = req0 | req1;
    end else begin
      granted = (owner_q == OWNER_M0) ? req0 : req1;
    end
    if (rst) begin
      granted = 1'b0;
    end
  end

  // Route the granted master onto the shared port; park it at zero otherwise.
  always_comb begin
    sel_addr   = '0;
    sel_w_data = '0;
    sel_w_sel  = '0;
    sel_re     = 1'b0;
    sel_we     = 1'b0;
    if (granted) begin
      if (sel_owner == OWNER_M0) begin
        sel_addr   = m0.addr;
        sel_w_data = m0.w_data;
        sel_w_sel  = m0.w_sel;
        sel_re     = m0.re;
        sel_we     = m0.we;
      end else begin
        sel_addr   = m1.addr;
        sel_w_data = m1.w_data;
        sel_w_sel  = m1.w_sel;
        sel_re     = m1.re;
        sel_we     = m1.we;
      end
    end
  end

  // Completion is judged on the granted transaction only, so a stray
  // slave response on an idle bus never counts.
  assign done = granted & ((sel_re & s.r_data_valid) | (sel_we & s.ready));

  // Next-state logic: lock the owner on grant, release on completion or abort.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (granted) begin
          owner_d = winner;
          if (done) begin
            last_d = winner;
          end else begin
            state_d = ARB_BUSY;
          end
        end
      end
      ARB_BUSY: begin
        if (!granted) begin
          state_d = ARB_IDLE;
        end else if (done) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end
      end
    endcase
  end

  // Arbiter state registers; last starts at m1 so m0 wins the first contest
  // in the alternating build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_M0;
      last_q  <= OWNER_M1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign s.addr   = sel_addr;
  assign s.w_data = sel_w_data;
  assign s.w_sel  = sel_w_sel;
  assign s.re     = sel_re;
  assign s.we     = sel_we;

  // Read data is broadcast; the handshakes qualify it per master.
  assign m0.r_data = s.r_data;
  assign m1.r_data = s.r_data;

  assign m0.ready        = granted & (sel_owner == OWNER_M0) & s.ready;
  assign m0.r_data_valid = granted & (sel_owner == OWNER_M0) & s.r_data_valid;
  assign m1.ready        = granted & (sel_owner == OWNER_M1) & s.ready;
  assign m1.r_data_valid = granted & (sel_owner == OWNER_M1) & s.r_data_valid;

  // A master never asks to read and write in the same request.
  a_m0_re_we_excl: assert property (@(posedge clk) disable iff (rst) !(m0.re && m0.we));
  a_m1_re_we_excl: assert property (@(posedge clk) disable iff (rst) !(m1.re && m1.we));

  // Only one master can ever see a handshake in a given cycle.
  a_resp_exclusive: assert property (@(posedge clk) disable iff (rst)
    !((m0.ready | m0.r_data_valid) && (m1.ready | m1.r_data_valid)));

  // An ungranted port is fully quiet.
  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    !granted |-> (s.addr == '0 && s.w_data == '0 && s.w_sel == '0 && !s.re && !s.we));

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Bench for bus_arbiter_2to1: directed transactions from both masters
// against a behavioural slave with programmable latency. Expected
// completions are queued in order as stimulus is issued; a negedge
// monitor pops one entry per master handshake and compares it.
module tb_bus_arbiter_2to1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_arbiter_2to1_if #(.AddrBusWidth(32), .BusWidth(32)) m0if ();
  bus_arbiter_2to1_if #(.AddrBusWidth(32), .BusWidth(32)) m1if ();
  bus_arbiter_2to1_if #(.AddrBusWidth(32), .BusWidth(32)) sif ();

  bus_arbiter_2to1 #(.AddrBusWidth(32), .BusWidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0if),
    .m1  (m1if),
    .s   (sif)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural slave ----------------
  int   lat;
  int   cnt;
  logic force_rsp;
  logic hit;

  assign hit               = (sif.re | sif.we) && (cnt == lat);
  assign sif.ready         = hit | force_rsp;
  assign sif.r_data_valid  = (hit & sif.re) | force_rsp;
  assign sif.r_data        = (sif.addr == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, sif.addr[15:0]};

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (hit || !(sif.re | sif.we)) cnt <= 0;
    else cnt <= cnt + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          idx;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } exp_t;

  exp_t sbq[$];

  task automatic push(input bit idx, input bit rd, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel);
    exp_t e;
    e.idx = idx; e.rd = rd; e.addr = addr; e.data = data; e.sel = sel;
    sbq.push_back(e);
  endtask

  task automatic check_ev(input bit idx, input bit rd, input logic [31:0] rdata);
    exp_t e;
    logic [31:0] got;
    checks++;
    got = rd ? rdata : sif.w_data;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: m%0d rd=%0b addr=%h data=%h, expected no response",
               idx, rd, sif.addr, got);
      return;
    end
    e = sbq.pop_front();
    if (idx !== e.idx || rd !== e.rd || sif.addr !== e.addr || got !== e.data ||
        (!rd && sif.w_sel !== e.sel)) begin
      errors++;
      $display("FAIL sb_resp: got m%0d rd=%0b addr=%h data=%h sel=%h, expected m%0d rd=%0b addr=%h data=%h sel=%h",
               idx, rd, sif.addr, got, sif.w_sel, e.idx, e.rd, e.addr, e.data, e.sel);
    end
  endtask

  // Monitor: every master handshake outside reset consumes one expectation.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (m0if.ready | m0if.r_data_valid) check_ev(1'b0, m0if.r_data_valid, m0if.r_data);
      if (m1if.ready | m1if.r_data_valid) check_ev(1'b1, m1if.r_data_valid, m1if.r_data);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel);
    if (idx == 0) begin
      m0if.addr = addr; m0if.w_data = wdata; m0if.w_sel = sel; m0if.re = !we; m0if.we = we;
    end else begin
      m1if.addr = addr; m1if.w_data = wdata; m1if.w_sel = sel; m1if.re = !we; m1if.we = we;
    end
  endtask

  task automatic clr(input int idx);
    set_req(idx, 1'b0, 32'h0, 32'h0, 4'h0);
    if (idx == 0) m0if.re = 1'b0;
    else          m1if.re = 1'b0;
  endtask

  function automatic bit got_done(input int idx, input bit rd);
    if (idx == 0) return rd ? m0if.r_data_valid : m0if.ready;
    return rd ? m1if.r_data_valid : m1if.ready;
  endfunction

  task automatic wait_done(input int idx, input bit rd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (got_done(idx, rd)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One complete master transaction: raise, hold until done, drop.
  task automatic txn(input int idx, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] sel);
    bit ok;
    set_req(idx, we, addr, wdata, sel);
    wait_done(idx, !we, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout_m%0d: addr %h got no completion in 60 cycles, expected completion", idx, addr);
    end
    @(posedge clk); #1;
    clr(idx);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr(0);
    clr(1);
    force_rsp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    rst = 1'b1;
    lat = 1;
    force_rsp = 1'b0;
    clr(0);
    clr(1);

    // Reset state.
    @(negedge clk);
    chk("rst_s_re", {31'b0, sif.re}, 32'd0);
    chk("rst_s_we", {31'b0, sif.we}, 32'd0);
    chk("rst_m_hs", {28'b0, m0if.ready, m0if.r_data_valid, m1if.ready, m1if.r_data_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_s_addr", sif.addr, 32'h0);
    chk("idle_s_wdata", sif.w_data, 32'h0);
    chk("idle_s_sel", {28'b0, sif.w_sel}, 32'h0);
    @(posedge clk); #1;

    // 1. Single m0 read, 2-cycle slave, same-cycle grant.
    lat = 2;
    push(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h0);
    fork
      txn(0, 1'b0, 32'h100, 32'h0, 4'h0);
      begin
        @(negedge clk);
        chk("t1_s_re", {31'b0, sif.re}, 32'd1);
        chk("t1_s_addr", sif.addr, 32'h100);
      end
    join

    // 2. Simultaneous m0 read and m1 write.
    do_reset();
    lat = 1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b1, 32'h200, 32'hC0DE0200, 4'h0);
    push(1'b1, 1'b0, 32'h300, 32'h12345678, 4'hF);
`else
    push(1'b1, 1'b0, 32'h300, 32'h12345678, 4'hF);
    push(1'b0, 1'b1, 32'h200, 32'hC0DE0200, 4'h0);
`endif
    fork
      txn(0, 1'b0, 32'h200, 32'h0, 4'h0);
      txn(1, 1'b1, 32'h300, 32'h12345678, 4'hF);
    join

    // 3. Zero-wait slave, both masters issuing back to back.
    do_reset();
    lat = 0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b1, 32'h20, 32'hC0DE0020, 4'h0);
    push(1'b1, 1'b0, 32'h10, 32'h000000A0, 4'hF);
    push(1'b0, 1'b1, 32'h21, 32'hC0DE0021, 4'h0);
    push(1'b1, 1'b0, 32'h11, 32'h000000A1, 4'h3);
    push(1'b1, 1'b0, 32'h12, 32'h000000A2, 4'hC);
`else
    push(1'b1, 1'b0, 32'h10, 32'h000000A0, 4'hF);
    push(1'b1, 1'b0, 32'h11, 32'h000000A1, 4'h3);
    push(1'b1, 1'b0, 32'h12, 32'h000000A2, 4'hC);
    push(1'b0, 1'b1, 32'h20, 32'hC0DE0020, 4'h0);
    push(1'b0, 1'b1, 32'h21, 32'hC0DE0021, 4'h0);
`endif
    fork
      begin
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
        txn(0, 1'b0, 32'h21, 32'h0, 4'h0);
      end
      begin
        txn(1, 1'b1, 32'h10, 32'h000000A0, 4'hF);
        txn(1, 1'b1, 32'h11, 32'h000000A1, 4'h3);
        txn(1, 1'b1, 32'h12, 32'h000000A2, 4'hC);
      end
    join

    // 4. m1 requests while m0 owns the bus.
    do_reset();
    lat = 3;
    push(1'b0, 1'b1, 32'h400, 32'hC0DE0400, 4'h0);
    push(1'b1, 1'b1, 32'h500, 32'hC0DE0500, 4'h0);
    fork
      txn(0, 1'b0, 32'h400, 32'h0, 4'h0);
      begin
        @(posedge clk); #1;
        txn(1, 1'b0, 32'h500, 32'h0, 4'h0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t4_hold_addr", sif.addr, 32'h400);
        wait_done(0, 1'b1, ok);
        chk("t4_m0_done_seen", {31'b0, ok}, 32'd1);
        @(negedge clk);
        chk("t4_m1_next_re", {31'b0, sif.re}, 32'd1);
        chk("t4_m1_next_addr", sif.addr, 32'h500);
      end
    join

    // 5. Asynchronous reset in the middle of an m1 write.
    do_reset();
    lat = 5;
    set_req(1, 1'b1, 32'h600, 32'h55AA55AA, 4'hF);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h700, 32'h0, 4'h0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_s_we", {31'b0, sif.we}, 32'd0);
    chk("t5_rst_s_re", {31'b0, sif.re}, 32'd0);
    chk("t5_rst_m1_ready", {31'b0, m1if.ready}, 32'd0);
    clr(1);
    push(1'b0, 1'b1, 32'h700, 32'hC0DE0700, 4'h0);
    @(negedge clk);
    chk("t5_rst_hold_quiet", {30'b0, sif.re, sif.we}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_m0_granted", {31'b0, sif.re}, 32'd1);
    chk("t5_m0_addr", sif.addr, 32'h700);
    wait_done(0, 1'b1, ok);
    chk("t5_m0_done_seen", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    clr(0);

    // 6. m0 aborts a read; a late slave response is dropped.
    do_reset();
    lat = 10;
    set_req(0, 1'b0, 32'h800, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr(0);
    @(negedge clk);
    chk("t6_abort_quiet", {30'b0, sif.re, sif.we}, 32'd0);
    @(posedge clk); #1;
    force_rsp = 1'b1;
    @(negedge clk);
    chk("t6_late_rdv_dropped",
        {28'b0, m0if.ready, m0if.r_data_valid, m1if.ready, m1if.r_data_valid}, 32'd0);
    @(posedge clk); #1;
    force_rsp = 1'b0;
    lat = 1;
    push(1'b1, 1'b1, 32'h900, 32'hC0DE0900, 4'h0);
    txn(1, 1'b0, 32'h900, 32'h0, 4'h0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
